vga_plot_arbiter: RTL and testbench
===================================

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4096, the maximum number of consecutive cycles one owner keeps the grant while another requester waits.
REQ-002 The block SHALL have port clk, input, 1, the single system clock (CLOCK_50 domain).
REQ-003 The block SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 3, per-requester access request (0 = clear/background, 1 = sequence drawer, 2 = score/HUD).
REQ-005 The block SHALL have ports x0/x1/x2, input, 9 each, the requester pixel x.
REQ-006 The block SHALL have ports y0/y1/y2, input, 9 each, the requester pixel y.
REQ-007 The block SHALL have ports colour0/colour1/colour2, input, 6 each, the requester pixel colour.
REQ-008 The block SHALL have port plot_in, input, 3, the per-requester write enable.
REQ-009 The block SHALL have port gnt, output, 3, one-hot or zero grant.
REQ-010 The block SHALL have ports vga_x (9), vga_y (9), vga_colour (6) and vga_plot (1), all outputs, registered, to the vga_adapter plot port.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN and GAP.
REQ-013 The block SHALL keep a 2-bit round-robin pointer ptr with legal values 0..2 and a 2-bit owner register.
REQ-014 In IDLE, if any req bit is high at a rising edge, the winner SHALL be the first set bit searching ptr, ptr+1, ptr+2 (mod 3), and on that edge owner <= winner, gnt <= one-hot(winner), state <= OWN.
REQ-015 In IDLE with req == 0, gnt SHALL stay 0 and vga_plot SHALL be 0.
REQ-016 In OWN, at each edge vga_x/vga_y/vga_colour SHALL load the owner's inputs and vga_plot SHALL load plot_in[owner] & req[owner], giving 1-cycle latency.
REQ-017 plot_in from non-owners SHALL never reach vga_plot.
REQ-018 In OWN, a 16-bit hold counter SHALL be cleared on entry, increment each cycle and saturate at MAX_HOLD.
REQ-019 OWN SHALL exit to GAP when req[owner] is sampled low, or when hold counter == MAX_HOLD-1 and any other req bit is high (preemption).
REQ-020 On the exit edge the block SHALL set gnt <= 0 and ptr <= (owner+1) mod 3, and the owner's final-cycle plot SHALL still be forwarded on that edge.
REQ-021 If the hold counter expires and no other requester is waiting, the owner SHALL retain the grant indefinitely.
REQ-022 GAP SHALL last exactly one cycle with vga_plot 0 and gnt 0, then go to IDLE, giving a minimum 2-cycle hand-off between owners.
REQ-023 A preempted requester that keeps req high SHALL be re-arbitrated normally and may regain the grant after the others are served.
REQ-024 Simultaneous requests in IDLE SHALL be resolved solely by the REQ-014 search order.
REQ-025 Outside OWN, vga_x/vga_y/vga_colour SHALL hold their last value.

Reset
REQ-026 When resetn is low, the block SHALL asynchronously force state = IDLE, ptr = 0, owner = 0, hold counter = 0, gnt = 0, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0 and busy = 0.
REQ-027 Reset asserted mid-burst SHALL drop gnt and vga_plot immediately, and no pixel SHALL be written after reset release until a new grant is issued.

Verification
REQ-028 Scenario: req=3'b010, x1=9'd10, y1=9'd198, colour1=6'h3F, plot_in[1]=1 -> gnt=3'b010 after 1 edge; vga_x=10, vga_y=198, vga_colour=3F, vga_plot=1 one edge later.
REQ-029 Scenario: req=3'b111 from reset -> grants in order 001, 010, 100, each owner dropping req after 5 cycles; each hand-off shows 1 GAP cycle with vga_plot=0.
REQ-030 Scenario: MAX_HOLD=8, req0 held high, req2 asserted at cycle 2 -> gnt drops after 8 OWN cycles, gnt=3'b100 two edges later, then req0 is re-granted after req2 releases.
REQ-031 Scenario: MAX_HOLD=8, only req1 held high for 20 cycles -> gnt=3'b010 continuous, no GAP.
REQ-032 Scenario: owner 0 active with plot_in=3'b110 -> vga_plot=0 throughout (non-owner plots ignored).
REQ-033 Scenario: resetn pulsed low mid-burst -> gnt=0 and vga_plot=0 without waiting for a clock edge, ptr=0 afterwards, first grant after reset goes to requester 0 when req=3'b101.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing one VGA plot port among three pixel writers
module vga_plot_arbiter #(
    parameter int MAX_HOLD = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [8:0] x0,
    input  logic [8:0] x1,
    input  logic [8:0] x2,
    input  logic [8:0] y0,
    input  logic [8:0] y1,
    input  logic [8:0] y2,
    input  logic [5:0] colour0,
    input  logic [5:0] colour1,
    input  logic [5:0] colour2,
    input  logic [2:0] plot_in,
    output logic [2:0] gnt,
    output logic [8:0] vga_x,
    output logic [8:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_MAX  = 16'(MAX_HOLD);
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  owner;
    logic [1:0]  winner;
    logic [1:0]  owner_next_ptr;
    logic [15:0] hold_cnt;
    logic [2:0]  owner_onehot;
    logic [2:0]  winner_onehot;
    logic        any_req;
    logic        owner_req;
    logic        owner_plot;
    logic        others_req;
    logic        own_exit;
    logic [8:0]  sel_x;
    logic [8:0]  sel_y;
    logic [5:0]  sel_colour;

    assign any_req        = |req;
    assign owner_onehot   = 3'(3'b001 << owner);
    assign winner_onehot  = 3'(3'b001 << winner);
    assign owner_req      = |(req & owner_onehot);
    assign owner_plot     = |(plot_in & owner_onehot);
    assign others_req     = |(req & ~owner_onehot);
    assign owner_next_ptr = (owner == 2'd2) ? 2'd0 : owner + 2'd1;

    // Leave ownership when the owner lets go, or when its hold budget runs out while someone waits
    assign own_exit = !owner_req || ((hold_cnt == HOLD_LAST) && others_req);

    // Round-robin search starting at ptr: first set request bit wins
    always_comb begin
        winner = 2'd0;
        case (ptr)
            2'd1: begin
                if (req[1])      winner = 2'd1;
                else if (req[2]) winner = 2'd2;
                else             winner = 2'd0;
            end
            2'd2: begin
                if (req[2])      winner = 2'd2;
                else if (req[0]) winner = 2'd0;
                else             winner = 2'd1;
            end
            default: begin
                if (req[0])      winner = 2'd0;
                else if (req[1]) winner = 2'd1;
                else             winner = 2'd2;
            end
        endcase
    end

    // Pixel mux selecting the current owner's coordinates and colour
    always_comb begin
        sel_x      = x0;
        sel_y      = y0;
        sel_colour = colour0;
        case (owner)
            2'd1: begin
                sel_x      = x1;
                sel_y      = y1;
                sel_colour = colour1;
            end
            2'd2: begin
                sel_x      = x2;
                sel_y      = y2;
                sel_colour = colour2;
            end
            default: begin
                sel_x      = x0;
                sel_y      = y0;
                sel_colour = colour0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> OWN on any request, OWN -> GAP on exit, GAP always one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = any_req  ? S_OWN : S_IDLE;
            S_OWN:   state_nxt = own_exit ? S_GAP : S_OWN;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: busy whenever a grant or hand-off is in progress
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Arbitration bookkeeping: owner, pointer, hold counter and grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= 16'd0;
            gnt      <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        gnt      <= winner_onehot;
                        hold_cnt <= 16'd0;
                    end
                end
                S_OWN: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                    if (own_exit) begin
                        gnt <= 3'b000;
                        ptr <= owner_next_ptr;
                    end
                end
                default: begin
                    gnt <= 3'b000;
                end
            endcase
        end
    end

    // Registered plot port: only the owner's pixel passes, including its final-cycle write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= 9'd0;
            vga_y      <= 9'd0;
            vga_colour <= 6'd0;
            vga_plot   <= 1'b0;
        end else if (state == S_OWN) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= owner_plot & owner_req;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter with behavioural model
module tb_vga_plot_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] plot_in = 3'b000;
    logic [8:0] xa [3];
    logic [8:0] ya [3];
    logic [5:0] ca [3];
    logic [2:0] gnt;
    logic [8:0] vga_x;
    logic [8:0] vga_y;
    logic [5:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    // model state
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_owner = 0;
    int         m_own_cycles = 0;
    logic [2:0] m_gnt = 3'b000;
    logic [8:0] m_x = 9'd0;
    logic [8:0] m_y = 9'd0;
    logic [5:0] m_c = 6'd0;
    logic       m_plot = 1'b0;

    vga_plot_arbiter #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .x0         (xa[0]),
        .x1         (xa[1]),
        .x2         (xa[2]),
        .y0         (ya[0]),
        .y1         (ya[1]),
        .y2         (ya[2]),
        .colour0    (ca[0]),
        .colour1    (ca[1]),
        .colour2    (ca[2]),
        .plot_in    (plot_in),
        .gnt        (gnt),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_owner = 0; m_own_cycles = 0;
        m_gnt = 3'b000; m_x = 9'd0; m_y = 9'd0; m_c = 6'd0; m_plot = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs present at that edge
    task automatic model_step();
        bit found;
        bit leave;
        int idx;
        if (!resetn) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_plot = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_gnt = 3'b000;
                m_gnt[m_owner] = 1'b1;
                m_own_cycles = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_x = xa[m_owner];
            m_y = ya[m_owner];
            m_c = ca[m_owner];
            m_plot = plot_in[m_owner] & req[m_owner];
            leave = !req[m_owner];
            for (int k = 0; k < 3; k++)
                if (k != m_owner && req[k] && m_own_cycles == MH - 1) leave = 1'b1;
            m_own_cycles++;
            if (leave) begin
                m_gnt = 3'b000;
                m_ptr = (m_owner + 1) % 3;
                m_phase = 2;
            end
        end else begin
            m_plot = 1'b0;
            m_phase = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
        end
    end

    // Compare process: every cycle, all outputs against the model
    always @(negedge clk) begin
        if (cmp_on)
            chk("cycle_outputs",
                32'({gnt, vga_x, vga_y, vga_colour, vga_plot, busy}),
                32'({m_gnt, m_x, m_y, m_c, m_plot, (m_phase != 0)}));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req = 3'b000;
        plot_in = 3'b000;
        resetn = 1'b0;
        model_reset();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int cnt;
        bit seen;
        logic [2:0] ord [3];
        int n_ord;
        logic [2:0] last_g;
        int b;

        for (int i = 0; i < 3; i++) begin
            xa[i] = 9'd0; ya[i] = 9'd0; ca[i] = 6'd0;
        end
        tick();
        cmp_on = 1'b1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_plot", 32'(vga_plot), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_xy", 32'({vga_x, vga_y, vga_colour}), 32'h0);
        resetn = 1'b1;
        tick();
        chk("idle_no_req_gnt", 32'(gnt), 32'h0);

        // single requester, latency of grant and pixel
        req = 3'b010; xa[1] = 9'd10; ya[1] = 9'd198; ca[1] = 6'h3F; plot_in = 3'b010;
        tick();
        chk("s1_gnt", 32'(gnt), 32'h2);
        tick();
        chk("s1_x", 32'(vga_x), 32'd10);
        chk("s1_y", 32'(vga_y), 32'd198);
        chk("s1_colour", 32'(vga_colour), 32'h3F);
        chk("s1_plot", 32'(vga_plot), 32'h1);
        req = 3'b000; plot_in = 3'b000;
        tick(); tick(); tick();

        // all three requesting, each drops after 5 owned cycles
        do_reset();
        req = 3'b111; plot_in = 3'b111;
        n_ord = 0; last_g = 3'b000; cnt = 0;
        for (int i = 0; i < 60 && (req != 0 || busy); i++) begin
            tick();
            if (gnt != 3'b000) begin
                if (gnt != last_g && n_ord < 3) begin
                    ord[n_ord] = gnt;
                    n_ord++;
                end
                last_g = gnt;
                cnt++;
                if (cnt == 5) req = req & ~gnt;
            end else begin
                cnt = 0;
            end
        end
        chk("rr_count", 32'(n_ord), 32'd3);
        chk("rr_first", 32'(ord[0]), 32'h1);
        chk("rr_second", 32'(ord[1]), 32'h2);
        chk("rr_third", 32'(ord[2]), 32'h4);
        plot_in = 3'b000;

        // preemption after MAX_HOLD cycles
        do_reset();
        req = 3'b001;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 1) req = 3'b101;
            if (gnt == 3'b001) cnt++;
            else break;
        end
        chk("preempt_hold_cycles", 32'(cnt), 32'd8);
        chk("preempt_drop", 32'(gnt), 32'h0);
        tick();
        chk("preempt_gap", 32'(gnt), 32'h0);
        tick();
        chk("preempt_next", 32'(gnt), 32'h4);
        tick(); tick(); tick();
        req = 3'b001;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (gnt == 3'b001) seen = 1'b1;
        end
        chk("preempt_regrant", 32'(seen), 32'h1);

        // lone requester keeps grant past the hold budget
        do_reset();
        req = 3'b010;
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt == 3'b010 && busy) cnt++;
        end
        chk("lone_hold", 32'(cnt), 32'd20);

        // non-owner plot enables are ignored
        do_reset();
        req = 3'b001; plot_in = 3'b110;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vga_plot) cnt++;
        end
        chk("nonowner_plot", 32'(cnt), 32'd0);
        chk("nonowner_gnt", 32'(gnt), 32'h1);

        // async reset mid-burst, pointer returns to 0
        do_reset();
        req = 3'b010; plot_in = 3'b000;
        tick(); tick();
        req = 3'b000;
        tick(); tick(); tick();
        req = 3'b101; plot_in = 3'b101; xa[2] = 9'd300; ya[2] = 9'd7; ca[2] = 6'h15;
        tick();
        chk("ptr2_gnt", 32'(gnt), 32'h4);
        tick(); tick();
        chk("burst_plot", 32'(vga_plot), 32'h1);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_plot", 32'(vga_plot), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("post_reset_gnt", 32'(gnt), 32'h1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, 2);
                req[b] = ~req[b];
            end
            plot_in = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                xa[k] = 9'($urandom);
                ya[k] = 9'($urandom);
                ca[k] = 6'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                model_reset();
                tick();
                resetn = 1'b1;
            end
            tick();
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
